// File: rtl/time_of_day_counter.sv
// time_of_day_counter: 24 h hour/minute/second counter with front-panel set buttons.
// Define TOD_PRESCALER_EN to derive the 1 Hz tick from clk (CLK_DIV cycles) instead of sec_tick.
module time_of_day_counter #(
  parameter  int unsigned CLK_DIV = 50_000_000,
  localparam int unsigned HOUR_W  = 5,
  localparam int unsigned MIN_W   = 6,
  localparam int unsigned SEC_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sec_tick,
  input  logic              hour_btn,
  input  logic              min_btn,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic [SEC_W-1:0]  sec,
  output logic              oneday
);

  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);
  localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(59);
  localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(59);

  logic tick;

`ifdef TOD_PRESCALER_EN
  localparam int unsigned      PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] presc;
  logic             unused_sec_tick;

  // Free-running divider; never paused by button edges, so a dropped tick is lost.
  always_ff @(posedge clk) begin
    if (reset)
      presc <= '0;
    else if (presc == PRE_MAX)
      presc <= '0;
    else
      presc <= presc + PRE_W'(1);
  end

  assign tick            = (presc == PRE_MAX);
  assign unused_sec_tick = sec_tick;
`else
  // A zero divisor is meaningless; it also keeps CLK_DIV referenced in this build.
  assign tick = sec_tick && (CLK_DIV != 0);
`endif

  logic hour_prev, min_prev;
  logic hour_edge, min_edge;

  // Previous-level registers load the live level in reset too: a held button gives no edge.
  always_ff @(posedge clk) begin
    hour_prev <= hour_btn;
    min_prev  <= min_btn;
  end

  assign hour_edge = hour_btn & ~hour_prev;
  assign min_edge  = min_btn  & ~min_prev;

  logic [HOUR_W-1:0] hour_n;
  logic [MIN_W-1:0]  min_n;
  logic [SEC_W-1:0]  sec_n;
  logic              oneday_n;

  // Button edges take priority and swallow a coincident tick.
  always_comb begin
    hour_n   = hour;
    min_n    = min;
    sec_n    = sec;
    oneday_n = 1'b0;
    if (hour_edge || min_edge) begin
      if (hour_edge)
        hour_n = (hour == HOUR_MAX) ? '0 : hour + HOUR_W'(1);
      if (min_edge) begin
        min_n = (min == MIN_MAX) ? '0 : min + MIN_W'(1);
        sec_n = '0;
      end
    end else if (tick) begin
      if (sec == SEC_MAX) begin
        sec_n = '0;
        if (min == MIN_MAX) begin
          min_n = '0;
          if (hour == HOUR_MAX) begin
            hour_n   = '0;
            oneday_n = 1'b1;
          end else begin
            hour_n = hour + HOUR_W'(1);
          end
        end else begin
          min_n = min + MIN_W'(1);
        end
      end else begin
        sec_n = sec + SEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hour   <= '0;
      min    <= '0;
      sec    <= '0;
      oneday <= 1'b0;
    end else begin
      hour   <= hour_n;
      min    <= min_n;
      sec    <= sec_n;
      oneday <= oneday_n;
    end
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter: a seconds-of-day reference model predicts
// each cycle's outputs; a posedge monitor pops and compares them.
module tb_time_of_day_counter;

  localparam int unsigned TB_DIV = 4;

  logic       clk;
  logic       reset;
  logic       sec_tick;
  logic       hour_btn;
  logic       min_btn;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       oneday;

  time_of_day_counter #(.CLK_DIV(TB_DIV)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .hour_btn(hour_btn),
    .min_btn(min_btn), .hour(hour), .min(min), .sec(sec), .oneday(oneday)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h;
    int m;
    int s;
    bit od;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int mh = 0, mm = 0, ms = 0, mk = 0;
  bit mod_od = 0, mhp = 0, mmp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's prediction for the following posedge.
  task automatic step(input bit r, input bit tk, input bit hb, input bit mb);
    bit he, me, mt;
    int secs;
    exp_t e;
    @(negedge clk);
    reset = r; sec_tick = tk; hour_btn = hb; min_btn = mb;
    if (r) begin
      mh = 0; mm = 0; ms = 0; mod_od = 0; mk = 0;
      mhp = hb; mmp = mb;
    end else begin
      he = hb && !mhp;
      me = mb && !mmp;
      mhp = hb; mmp = mb;
`ifdef TOD_PRESCALER_EN
      mt = ((mk % TB_DIV) == TB_DIV - 1);
      mk++;
`else
      mt = tk;
`endif
      mod_od = 0;
      if (he || me) begin
        if (he) mh = (mh + 1) % 24;
        if (me) begin
          mm = (mm + 1) % 60;
          ms = 0;
        end
      end else if (mt) begin
        secs = (mh * 3600 + mm * 60 + ms + 1) % 86400;
        mh = secs / 3600;
        mm = (secs / 60) % 60;
        ms = secs % 60;
        mod_od = (secs == 0);
      end
    end
    e.h = mh; e.m = mm; e.s = ms; e.od = mod_od;
    sbq.push_back(e);
  endtask

  task automatic press_hour();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic press_min();
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  task automatic preset(input int h, input int m, input int s);
    step(1, 0, 0, 0);
    for (int i = 0; i < h; i++) press_hour();
    for (int i = 0; i < m; i++) press_min();
    for (int i = 0; i < s; i++) step(0, 1, 0, 0);
  endtask

  // Directed check of the state captured at the most recent posedge.
  task automatic dchk(input string name, input int h, input int m, input int s, input bit od);
    @(posedge clk);
    #2;
    chk({name, ".hour"}, 32'(hour), 32'(h));
    chk({name, ".min"}, 32'(min), 32'(m));
    chk({name, ".sec"}, 32'(sec), 32'(s));
    chk({name, ".oneday"}, 32'(oneday), 32'(od));
  endtask

  // Monitor: every posedge the DUT presents a new output word; compare the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb.hour", 32'(hour), 32'(e.h));
      chk("sb.min", 32'(min), 32'(e.m));
      chk("sb.sec", 32'(sec), 32'(e.s));
      chk("sb.oneday", 32'(oneday), 32'(e.od));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    bit hb, mb;
    reset = 1'b1; sec_tick = 1'b0; hour_btn = 1'b0; min_btn = 1'b0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    dchk("reset", 0, 0, 0, 0);

`ifdef TOD_PRESCALER_EN
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0);
    dchk("presc12", 0, 0, 3, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    dchk("presc15", 0, 0, 3, 0);
`else
    for (int i = 0; i < 61; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
    dchk("count61", 0, 1, 1, 0);

    preset(23, 59, 58);
    dchk("preset", 23, 59, 58, 0);
    step(0, 1, 0, 0);
    dchk("t59", 23, 59, 59, 0);
    step(0, 1, 0, 0);
    dchk("midnight", 0, 0, 0, 1);
    step(0, 0, 0, 0);
    dchk("after_mid", 0, 0, 0, 0);

    preset(23, 10, 20);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    dchk("hour_hold", 0, 10, 20, 0);
    for (int i = 0; i < 49; i++) press_min();
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0);
    dchk("pre_minwrap", 0, 59, 30, 0);
    press_min();
    dchk("minwrap", 0, 0, 0, 0);

    preset(5, 7, 33);
    step(0, 1, 0, 1);
    dchk("tick_drop", 5, 8, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    dchk("next_tick", 5, 8, 1, 0);

    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    dchk("both_btn", 6, 9, 0, 0);
`endif

    // Randomised traffic, including a run parked near midnight.
    preset(23, 59, 50);
    hb = 0; mb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) hb = !hb;
      if ($urandom_range(0, 7) == 0) mb = !mb;
      step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), hb, mb);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
